// File: rtl/phase_sequencer.sv
// Three-phase strobe sequencer: checks one-hot A->B->C ordering and turns strobes into stage enables.
// Optional stall detection is built only when PHASE_SEQ_STALL_DETECT_EN is defined.
module phase_sequencer #(
    parameter int unsigned CNT_WIDTH   = 16,
    parameter int unsigned STALL_LIMIT = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cycle_clock,
    input  logic                 ram_clock,
    input  logic                 internal_clock,
    input  logic                 error_clear,
    output logic                 fetch_en,
    output logic                 mem_en,
    output logic                 exec_en,
    output logic                 cycle_done,
    output logic [CNT_WIDTH-1:0] cycles_retired,
    output logic                 running,
    output logic                 stalled,
    output logic                 phase_error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXP_B,
        S_EXP_C,
        S_EXP_A,
        S_ERROR
    } state_t;

    state_t                 r_state;
    logic                   r_fetch_en;
    logic                   r_mem_en;
    logic                   r_exec_en;
    logic                   r_cycle_done;
    logic [CNT_WIDTH-1:0]   r_cycles;

    logic [2:0] w_p;
    logic [2:0] w_exp_phase;
    logic       w_multi_hot;
    logic       w_running;

    if (STALL_LIMIT == 0) begin : g_bad_stall_limit
        $error("phase_sequencer: STALL_LIMIT must be at least 1");
    end

    assign w_p = {cycle_clock, ram_clock, internal_clock};

    always_comb begin
        w_multi_hot = 1'b0;
        case (w_p)
            3'b011, 3'b101, 3'b110, 3'b111: w_multi_hot = 1'b1;
            default:                        w_multi_hot = 1'b0;
        endcase
    end

    always_comb begin
        w_exp_phase = 3'b000;
        case (r_state)
            S_EXP_B: w_exp_phase = 3'b010;
            S_EXP_C: w_exp_phase = 3'b001;
            S_EXP_A: w_exp_phase = 3'b100;
            default: w_exp_phase = 3'b000;
        endcase
    end

    assign w_running = (r_state == S_EXP_B) || (r_state == S_EXP_C) || (r_state == S_EXP_A);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_fetch_en   <= 1'b0;
            r_mem_en     <= 1'b0;
            r_exec_en    <= 1'b0;
            r_cycle_done <= 1'b0;
            r_cycles     <= '0;
        end else begin
            r_fetch_en   <= 1'b0;
            r_mem_en     <= 1'b0;
            r_exec_en    <= 1'b0;
            r_cycle_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // Stray B/C strobes here belong to a partial cycle and are dropped.
                    if (w_p == 3'b100) begin
                        r_fetch_en <= 1'b1;
                        r_state    <= S_EXP_B;
                    end
                end
                S_EXP_B, S_EXP_C, S_EXP_A: begin
                    if (w_p == 3'b000) begin
                        r_state <= r_state;
                    end else if (w_p == w_exp_phase) begin
                        case (r_state)
                            S_EXP_B: begin
                                r_mem_en <= 1'b1;
                                r_state  <= S_EXP_C;
                            end
                            S_EXP_C: begin
                                r_exec_en    <= 1'b1;
                                r_cycle_done <= 1'b1;
                                r_cycles     <= r_cycles + CNT_WIDTH'(1);
                                r_state      <= S_EXP_A;
                            end
                            default: begin
                                r_fetch_en <= 1'b1;
                                r_state    <= S_EXP_B;
                            end
                        endcase
                    end else begin
                        r_state <= S_ERROR;
                    end
                end
                S_ERROR: begin
                    // A multi-hot strobe arriving with the clear counts as a fresh error.
                    if (error_clear && !w_multi_hot) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign fetch_en       = r_fetch_en;
    assign mem_en         = r_mem_en;
    assign exec_en        = r_exec_en;
    assign cycle_done     = r_cycle_done;
    assign cycles_retired = r_cycles;
    assign running        = w_running;
    assign phase_error    = (r_state == S_ERROR);

`ifdef PHASE_SEQ_STALL_DETECT_EN
    localparam int unsigned STALL_W = (STALL_LIMIT < 1) ? 1 : $clog2(STALL_LIMIT + 1);

    logic [STALL_W-1:0] r_stall_cnt;

    // Counting only while running and idle-strobed also covers the clears on entry to IDLE/ERROR.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (w_running && (w_p == 3'b000)) begin
            if (r_stall_cnt < STALL_W'(STALL_LIMIT)) begin
                r_stall_cnt <= r_stall_cnt + STALL_W'(1);
            end
        end else begin
            r_stall_cnt <= '0;
        end
    end

    assign stalled = (r_stall_cnt >= STALL_W'(STALL_LIMIT));
`else
    assign stalled = 1'b0;
`endif

endmodule

// File: tb/tb_phase_sequencer.sv
// Bench for phase_sequencer (CNT_WIDTH=4, STALL_LIMIT=3); stall expectations apply when PHASE_SEQ_STALL_DETECT_EN is defined.
module tb_phase_sequencer;

    localparam int unsigned CW = 4;
`ifdef PHASE_SEQ_STALL_DETECT_EN
    localparam bit STALL_ON = 1'b1;
`else
    localparam bit STALL_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cycle_clock = 1'b0;
    logic          ram_clock = 1'b0;
    logic          internal_clock = 1'b0;
    logic          error_clear = 1'b0;
    logic          fetch_en, mem_en, exec_en, cycle_done;
    logic [CW-1:0] cycles_retired;
    logic          running, stalled, phase_error;

    phase_sequencer #(
        .CNT_WIDTH  (CW),
        .STALL_LIMIT(3)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .cycle_clock   (cycle_clock),
        .ram_clock     (ram_clock),
        .internal_clock(internal_clock),
        .error_clear   (error_clear),
        .fetch_en      (fetch_en),
        .mem_en        (mem_en),
        .exec_en       (exec_en),
        .cycle_done    (cycle_done),
        .cycles_retired(cycles_retired),
        .running       (running),
        .stalled       (stalled),
        .phase_error   (phase_error)
    );

    always #5 clk = ~clk;

    // exp = {fetch, mem, exec, done, count[3:0], running, stalled, error}
    typedef struct {
        logic [2:0]  p;
        logic        clr;
        logic        rst;
        logic [10:0] exp;
    } vec_t;

    vec_t        tbl[$];
    logic [10:0] sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          step_no = 0;
    logic [10:0] w_want;
    logic [10:0] w_got;

    function automatic vec_t mk(input logic [2:0] p, input logic clr, input logic rst,
                                input logic [3:0] en, input int cnt, input logic [2:0] rse);
        vec_t v;
        v.p   = p;
        v.clr = clr;
        v.rst = rst;
        v.exp = {en, 4'(cnt), rse[2], rse[1] & STALL_ON, rse[0]};
        return v;
    endfunction

    task automatic drive(input vec_t v);
        @(negedge clk);
        {cycle_clock, ram_clock, internal_clock} = v.p;
        error_clear = v.clr;
        reset       = v.rst;
        sb.push_back(v.exp);
    endtask

    // Monitor: one expected record per sampled clock, checked just after the edge.
    always @(posedge clk) begin
        #1;
        if (sb.size() != 0) begin
            w_want = sb.pop_front();
            w_got  = {fetch_en, mem_en, exec_en, cycle_done, cycles_retired,
                      running, stalled, phase_error};
            n_cmp++;
            if (w_got !== w_want) begin
                n_bad++;
                $display("FAIL outputs step %0d: got %b, want %b (f m x d cnt run stl err)",
                         step_no, w_got, w_want);
            end
            step_no++;
        end
    end

    initial begin
        // Reset, then four clean A-B-C cycles.
        tbl.push_back(mk(3'b000, 0, 1, 4'b0000, 0, 3'b000));
        for (int k = 1; k <= 4; k++) begin
            tbl.push_back(mk(3'b100, 0, 0, 4'b1000, k - 1, 3'b100));
            tbl.push_back(mk(3'b010, 0, 0, 4'b0100, k - 1, 3'b100));
            tbl.push_back(mk(3'b001, 0, 0, 4'b0011, k,     3'b100));
        end
        // Stray B and C in IDLE dropped, then one full cycle.
        tbl.push_back(mk(3'b000, 0, 1, 4'b0000, 0, 3'b000));
        tbl.push_back(mk(3'b010, 0, 0, 4'b0000, 0, 3'b000));
        tbl.push_back(mk(3'b001, 0, 0, 4'b0000, 0, 3'b000));
        tbl.push_back(mk(3'b100, 0, 0, 4'b1000, 0, 3'b100));
        tbl.push_back(mk(3'b010, 0, 0, 4'b0100, 0, 3'b100));
        tbl.push_back(mk(3'b001, 0, 0, 4'b0011, 1, 3'b100));
        // Halt pause of five zero clocks before C; stalled from third zero.
        tbl.push_back(mk(3'b000, 0, 1, 4'b0000, 0, 3'b000));
        tbl.push_back(mk(3'b100, 0, 0, 4'b1000, 0, 3'b100));
        tbl.push_back(mk(3'b010, 0, 0, 4'b0100, 0, 3'b100));
        tbl.push_back(mk(3'b000, 0, 0, 4'b0000, 0, 3'b100));
        tbl.push_back(mk(3'b000, 0, 0, 4'b0000, 0, 3'b100));
        tbl.push_back(mk(3'b000, 0, 0, 4'b0000, 0, 3'b110));
        tbl.push_back(mk(3'b000, 0, 0, 4'b0000, 0, 3'b110));
        tbl.push_back(mk(3'b000, 0, 0, 4'b0000, 0, 3'b110));
        tbl.push_back(mk(3'b001, 0, 0, 4'b0011, 1, 3'b100));
        // Order error A then C; sticky until clear; clear outside ERROR is ignored.
        tbl.push_back(mk(3'b100, 0, 0, 4'b1000, 1, 3'b100));
        tbl.push_back(mk(3'b001, 0, 0, 4'b0000, 1, 3'b001));
        tbl.push_back(mk(3'b000, 0, 0, 4'b0000, 1, 3'b001));
        tbl.push_back(mk(3'b000, 1, 0, 4'b0000, 1, 3'b000));
        tbl.push_back(mk(3'b100, 0, 0, 4'b1000, 1, 3'b100));
        tbl.push_back(mk(3'b010, 1, 0, 4'b0100, 1, 3'b100));
        tbl.push_back(mk(3'b001, 0, 0, 4'b0011, 2, 3'b100));
        // Multi-hot in EXP_B; clear with multi-hot keeps ERROR; clear with A only returns to IDLE.
        tbl.push_back(mk(3'b100, 0, 0, 4'b1000, 2, 3'b100));
        tbl.push_back(mk(3'b110, 0, 0, 4'b0000, 2, 3'b001));
        tbl.push_back(mk(3'b011, 1, 0, 4'b0000, 2, 3'b001));
        tbl.push_back(mk(3'b100, 0, 0, 4'b0000, 2, 3'b001));
        tbl.push_back(mk(3'b100, 1, 0, 4'b0000, 2, 3'b000));
        tbl.push_back(mk(3'b100, 0, 0, 4'b1000, 2, 3'b100));
        tbl.push_back(mk(3'b100, 0, 0, 4'b0000, 2, 3'b001));
        // Reset dominates in ERROR, even with a clear and multi-hot input.
        tbl.push_back(mk(3'b111, 1, 1, 4'b0000, 0, 3'b000));

        foreach (tbl[i]) drive(tbl[i]);

        // Counter wrap: 17 cycles on a 4-bit counter ends at 1.
        drive(mk(3'b000, 0, 1, 4'b0000, 0, 3'b000));
        for (int i = 0; i < 17; i++) begin
            drive(mk(3'b100, 0, 0, 4'b1000, i % 16,       3'b100));
            drive(mk(3'b010, 0, 0, 4'b0100, i % 16,       3'b100));
            drive(mk(3'b001, 0, 0, 4'b0011, (i + 1) % 16, 3'b100));
        end

        // Reset in EXP_C: outputs clear, a following C is ignored as in IDLE.
        drive(mk(3'b100, 0, 0, 4'b1000, 1, 3'b100));
        drive(mk(3'b010, 0, 0, 4'b0100, 1, 3'b100));
        drive(mk(3'b001, 0, 1, 4'b0000, 0, 3'b000));
        drive(mk(3'b001, 0, 0, 4'b0000, 0, 3'b000));
        drive(mk(3'b100, 0, 0, 4'b1000, 0, 3'b100));

        @(negedge clk);
        {cycle_clock, ram_clock, internal_clock} = 3'b000;
        error_clear = 1'b0;
        for (int k = 0; k < 5 && sb.size() != 0; k++) @(posedge clk);
        #2;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d records left, want 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
